// File: rtl/sel_pri_arb_32x4_if.sv
`default_nettype none
// ==========================================================================
// sel_pri_arb_32x4_if : request / output-buffer bundle of the 4:1 arbiter.
// Revision 1.0
// ==========================================================================
interface sel_pri_arb_32x4_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       req_valid;
  logic [3:0]       req_last;
  logic [3:0]       req_ready;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [WIDTH-1:0] req_data2;
  logic [WIDTH-1:0] req_data3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_sel;
  logic             out_last;
  logic             out_trunc;

  modport master (
    input  req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
    output req_ready, out_valid, out_data, out_sel, out_last, out_trunc
  );

  modport slave (
    output req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
    input  req_ready, out_valid, out_data, out_sel, out_last, out_trunc
  );
endinterface
`default_nettype wire

// File: rtl/sel_pri_arb_32x4.sv
`default_nettype none
// ==========================================================================
// sel_pri_arb_32x4 : fixed-priority 4:1 arbiter with burst lock, registered out.
// Revision 1.0
// ==========================================================================
module sel_pri_arb_32x4 #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sel_pri_arb_32x4_if.master   bus
);
  localparam logic [0:0] c_IDLE      = 1'b0;
  localparam logic [0:0] c_LOCK      = 1'b1;
  localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);
  localparam bit         c_CAN_LOCK  = (MAX_BURST > 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [7:0]       count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [3:0]       out_sel_q, out_sel_d;
  logic             out_last_q, out_last_d;
  logic             out_trunc_q, out_trunc_d;

  logic             w_can_accept;
  logic             w_any_valid;
  logic [1:0]       w_win;
  logic [1:0]       w_src;
  logic [3:0]       w_ready;
  logic             w_accept;
  logic             w_beat_last;
  logic [7:0]       w_count_inc;
  logic [WIDTH-1:0] w_data;

  assign w_can_accept = !out_valid_q || bus.out_ready;
  assign w_any_valid  = |bus.req_valid;
  assign w_src        = (state_q == c_LOCK) ? grant_q : w_win;
  assign w_accept     = |(bus.req_valid & w_ready);
  assign w_beat_last  = bus.req_last[w_src];
  assign w_count_inc  = count_q + 8'd1;

  always_comb begin
    w_win = 2'd3;
    if (bus.req_valid[0])      w_win = 2'd0;
    else if (bus.req_valid[1]) w_win = 2'd1;
    else if (bus.req_valid[2]) w_win = 2'd2;
  end

  // A locked grantee is offered ready even when idle, so it may resume at will.
  always_comb begin
    w_ready = 4'b0000;
    if (!reset) begin
      if (state_q == c_LOCK)  w_ready[grant_q] = w_can_accept;
      else if (w_any_valid)   w_ready = (4'b0001 << w_win) & {4{w_can_accept}};
    end
  end

  always_comb begin
    case (w_src)
      2'd0:    w_data = bus.req_data0;
      2'd1:    w_data = bus.req_data1;
      2'd2:    w_data = bus.req_data2;
      default: w_data = bus.req_data3;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    out_trunc_d = out_trunc_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = w_data;
      out_sel_d   = 4'b0001 << w_src;
      if (state_q == c_IDLE) begin
        if (!w_beat_last && c_CAN_LOCK) begin
          state_d     = c_LOCK;
          grant_d     = w_src;
          count_d     = 8'd1;
          out_last_d  = 1'b0;
          out_trunc_d = 1'b0;
        end else begin
          // Only reachable without req_last when MAX_BURST is 1.
          out_last_d  = 1'b1;
          out_trunc_d = !w_beat_last;
        end
      end else begin
        count_d = w_count_inc;
        if (w_beat_last || (w_count_inc == c_MAX_BURST)) begin
          state_d     = c_IDLE;
          count_d     = 8'd0;
          out_last_d  = 1'b1;
          out_trunc_d = !w_beat_last;
        end else begin
          out_last_d  = 1'b0;
          out_trunc_d = 1'b0;
        end
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_sel_d   = 4'b0000;
      out_last_d  = 1'b0;
      out_trunc_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_IDLE;
      grant_q     <= 2'd0;
      count_q     <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 4'b0000;
      out_last_q  <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_trunc = out_trunc_q;
endmodule
`default_nettype wire

// File: tb/tb_sel_pri_arb_32x4.sv
`default_nettype none
// ==========================================================================
// tb_sel_pri_arb_32x4 : directed stimulus, burst-level model, per-cycle compare.
// Revision 1.0
// ==========================================================================
module tb_sel_pri_arb_32x4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sel_pri_arb_32x4_if #(.WIDTH(WIDTH)) bus ();

  sel_pri_arb_32x4 #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 = nobody) and how many beats the burst has used.
  int          m_owner = -1;
  int          m_beats = 0;
  logic        m_v     = 1'b0;
  logic [31:0] m_data  = '0;
  logic [3:0]  m_sel   = '0;
  logic        m_last  = 1'b0;
  logic        m_trunc = 1'b0;

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    r = 4'b0000;
    if (reset) return r;
    if (m_v && !bus.out_ready) return r;
    if (m_owner >= 0) r[m_owner] = 1'b1;
    else for (int i = 3; i >= 0; i--) if (bus.req_valid[i]) r = 4'b0001 << i;
    return r;
  endfunction

  always @(posedge clk) begin
    logic [3:0] acc;
    int         src;
    logic       lst;
    acc = model_ready() & bus.req_valid;
    if (reset) begin
      m_owner = -1; m_beats = 0; m_v = 1'b0; m_data = '0;
      m_sel = '0; m_last = 1'b0; m_trunc = 1'b0;
    end else if (acc != 4'b0000) begin
      src = 0;
      for (int i = 0; i < 4; i++) if (acc[i]) src = i;
      lst = bus.req_last[src];
      m_beats++;
      m_v   = 1'b1;
      m_sel = acc;
      case (src)
        0:       m_data = bus.req_data0;
        1:       m_data = bus.req_data1;
        2:       m_data = bus.req_data2;
        default: m_data = bus.req_data3;
      endcase
      if (lst || m_beats == MAX_BURST) begin
        m_owner = -1; m_beats = 0; m_last = 1'b1; m_trunc = !lst;
      end else begin
        m_owner = src; m_last = 1'b0; m_trunc = 1'b0;
      end
    end else if (bus.out_ready) begin
      m_v = 1'b0; m_sel = '0;
    end
  end

  always @(negedge clk) begin
    chk("model req_ready", {28'd0, bus.req_ready}, {28'd0, model_ready()});
    chk("model out_valid", {31'd0, bus.out_valid}, {31'd0, m_v});
    chk("model out_sel",   {28'd0, bus.out_sel},   {28'd0, m_sel});
    if (m_v) begin
      chk("model out_data",  bus.out_data, m_data);
      chk("model out_last",  {31'd0, bus.out_last},  {31'd0, m_last});
      chk("model out_trunc", {31'd0, bus.out_trunc}, {31'd0, m_trunc});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l);
    bus.req_valid = v;
    bus.req_last  = l;
  endtask

  initial begin
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b0000;
    bus.req_data0 = 32'hA0A0A0A0;
    bus.req_data1 = 32'h11111111;
    bus.req_data2 = 32'h22222222;
    bus.req_data3 = 32'h33333333;
    bus.out_ready = 1'b1;
    cyc(); cyc();
    chk("reset req_ready", {28'd0, bus.req_ready}, 32'h0);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'h0);
    chk("reset out_data",  bus.out_data, 32'h0);
    chk("reset out_sel",   {28'd0, bus.out_sel}, 32'h0);
    chk("reset out_last",  {31'd0, bus.out_last}, 32'h0);
    chk("reset out_trunc", {31'd0, bus.out_trunc}, 32'h0);
    drive(4'b0000, 4'b0000);
    reset = 1'b0;
    cyc();

    // Priority, single beats
    drive(4'b1110, 4'b1111); #1;
    chk("prio ready1", {28'd0, bus.req_ready}, 32'h2);
    cyc();
    chk("prio sel1",  {28'd0, bus.out_sel}, 32'h2);
    chk("prio data1", bus.out_data, 32'h11111111);
    chk("prio last1", {31'd0, bus.out_last}, 32'h1);
    drive(4'b1100, 4'b1111); #1;
    chk("prio ready2", {28'd0, bus.req_ready}, 32'h4);
    cyc();
    chk("prio sel2",  {28'd0, bus.out_sel}, 32'h4);
    chk("prio data2", bus.out_data, 32'h22222222);
    drive(4'b1000, 4'b1111); #1;
    chk("prio ready3", {28'd0, bus.req_ready}, 32'h8);
    cyc();
    chk("prio sel3",  {28'd0, bus.out_sel}, 32'h8);
    chk("prio data3", bus.out_data, 32'h33333333);
    chk("prio last3", {31'd0, bus.out_last}, 32'h1);
    drive(4'b0000, 4'b0000);
    cyc();
    chk("idle drain valid", {31'd0, bus.out_valid}, 32'h0);
    chk("idle drain sel",   {28'd0, bus.out_sel}, 32'h0);

    // Burst lock: requester 2, three beats; requester 0 arrives after beat 1
    drive(4'b0100, 4'b0000);
    cyc();
    chk("lock b1 sel",  {28'd0, bus.out_sel}, 32'h4);
    chk("lock b1 last", {31'd0, bus.out_last}, 32'h0);
    drive(4'b0101, 4'b0000); #1;
    chk("lock ignores r0", {28'd0, bus.req_ready}, 32'h4);
    cyc();
    chk("lock b2 sel", {28'd0, bus.out_sel}, 32'h4);
    drive(4'b0101, 4'b0100);
    cyc();
    chk("lock b3 sel",   {28'd0, bus.out_sel}, 32'h4);
    chk("lock b3 last",  {31'd0, bus.out_last}, 32'h1);
    chk("lock b3 trunc", {31'd0, bus.out_trunc}, 32'h0);
    drive(4'b0001, 4'b0001); #1;
    chk("post lock ready0", {28'd0, bus.req_ready}, 32'h1);
    cyc();
    chk("post lock sel0", {28'd0, bus.out_sel}, 32'h1);
    chk("post lock data0", bus.out_data, 32'hA0A0A0A0);
    drive(4'b0000, 4'b0000);
    cyc();

    // Truncation after MAX_BURST beats from requester 3
    drive(4'b1000, 4'b0000);
    for (int k = 1; k <= MAX_BURST; k++) begin
      bus.req_data3 = 32'h30000000 + 32'(k);
      cyc();
      chk("trunc sel",   {28'd0, bus.out_sel}, 32'h8);
      chk("trunc data",  bus.out_data, 32'h30000000 + 32'(k));
      chk("trunc last",  {31'd0, bus.out_last},  (k == MAX_BURST) ? 32'h1 : 32'h0);
      chk("trunc flag",  {31'd0, bus.out_trunc}, (k == MAX_BURST) ? 32'h1 : 32'h0);
    end
    drive(4'b1010, 4'b1111); #1;
    chk("trunc rearb ready", {28'd0, bus.req_ready}, 32'h2);
    cyc();
    chk("trunc rearb sel", {28'd0, bus.out_sel}, 32'h2);
    drive(4'b0000, 4'b0000);
    cyc();

    // Backpressure: hold the buffer full, then drain and refill together
    bus.req_data0 = 32'hDEADBEEF;
    drive(4'b0001, 4'b0001);
    cyc();
    bus.out_ready = 1'b0;
    bus.req_data2 = 32'h5555AAAA;
    drive(4'b0100, 4'b0100);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp ready", {28'd0, bus.req_ready}, 32'h0);
      cyc();
      chk("bp valid", {31'd0, bus.out_valid}, 32'h1);
      chk("bp data",  bus.out_data, 32'hDEADBEEF);
      chk("bp sel",   {28'd0, bus.out_sel}, 32'h1);
      chk("bp last",  {31'd0, bus.out_last}, 32'h1);
    end
    bus.out_ready = 1'b1; #1;
    chk("refill ready", {28'd0, bus.req_ready}, 32'h4);
    cyc();
    chk("refill valid", {31'd0, bus.out_valid}, 32'h1);
    chk("refill sel",   {28'd0, bus.out_sel}, 32'h4);
    chk("refill data",  bus.out_data, 32'h5555AAAA);
    drive(4'b0000, 4'b0000);
    cyc();

    // Reset during beat 2 of a requester-1 burst
    drive(4'b0010, 4'b0000);
    cyc();
    chk("rst b1 sel", {28'd0, bus.out_sel}, 32'h2);
    drive(4'b0011, 4'b0000);
    reset = 1'b1; #1;
    chk("rst ready", {28'd0, bus.req_ready}, 32'h0);
    cyc();
    chk("rst valid", {31'd0, bus.out_valid}, 32'h0);
    chk("rst sel",   {28'd0, bus.out_sel}, 32'h0);
    reset = 1'b0;
    drive(4'b0011, 4'b0001); #1;
    chk("post rst ready0", {28'd0, bus.req_ready}, 32'h1);
    cyc();
    chk("post rst sel0", {28'd0, bus.out_sel}, 32'h1);

    // Idle
    drive(4'b0000, 4'b0000); #1;
    chk("idle ready", {28'd0, bus.req_ready}, 32'h0);
    cyc(); cyc();
    chk("idle valid", {31'd0, bus.out_valid}, 32'h0);
    chk("idle sel",   {28'd0, bus.out_sel}, 32'h0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sel_pri_arb_32x4.md
Name: sel_pri_arb_32x4

Overview:
- Four-requester fixed-priority arbiter with burst lock. Requester 0 has the highest priority.
- It is the producing end of the one-hot priority select path. It decides which of four 32-bit sources wins.
- It registers the winning beat, together with its one-hot source select, into a single-entry output buffer.
- The buffer uses a valid/ready handshake toward the downstream consumer.

Parameters:
- WIDTH, 32, data width of every source and of the output.
- MAX_BURST, 8, maximum beats per locked grant before forced release (legal range 1..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  4  per-requester beat valid; bit i belongs to requester i.
- req_last  input  4  per-requester last-beat-of-burst flag; qualified by req_valid.
- req_data0  input  WIDTH  requester 0 data.
- req_data1  input  WIDTH  requester 1 data.
- req_data2  input  WIDTH  requester 2 data.
- req_data3  input  WIDTH  requester 3 data.
- req_ready  output  4  per-requester accept; at most one bit set.
- out_valid  output  1  output buffer holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  buffered beat data.
- out_sel  output  4  one-hot source of the buffered beat; 0 when empty.
- out_last  output  1  buffered beat closes its grant (req_last, or forced).
- out_trunc  output  1  grant was force-released by MAX_BURST; valid with out_last.

Behaviour:
- Reset (reset=1 at an edge):
  - state=IDLE, beat counter=0.
  - out_valid=0, out_data=0, out_sel=0, out_last=0, out_trunc=0.
  - req_ready forced to 0 combinationally while reset is high.
  - Reset mid-burst discards the lock and any buffered beat; nothing is replayed.
- can_accept = !out_valid | out_ready (the buffer refills in the same cycle it drains).
- A beat is accepted from requester i when req_valid[i] & req_ready[i].
- IDLE state:
  - win = lowest index i with req_valid[i]=1.
  - req_ready = onehot(win) & {4{can_accept}}; req_ready=0 if no requester is valid.
  - On accept with req_last[win]=0 and MAX_BURST>1: grant<=win, count<=1, go to LOCK.
  - Otherwise stay in IDLE, and the beat carries out_last=1.
- LOCK state:
  - Only the granted requester may get req_ready (= can_accept).
  - Higher-priority requesters are ignored until the lock is released.
  - On accept: count<=count+1.
  - If req_last=1, return to IDLE with out_last=1, out_trunc=0.
  - Else if count+1 == MAX_BURST, return to IDLE with out_last=1, out_trunc=1.
  - A lock with no req_valid from the grantee stalls indefinitely; there is no timeout.
- MAX_BURST=1: every accepted beat has out_last=1. A beat with req_last=0 also gets out_trunc=1. LOCK is never entered.
- Buffer update on accept:
  - out_valid<=1, out_data<=selected req_data, out_sel<=onehot(source).
  - out_last and out_trunc are set as above.
- Buffer drain without accept: out_valid<=0 and out_sel<=0. out_data holds its last value; its content is don't-care when out_valid=0.
- Latency: accepted at edge t -> visible on outputs after edge t. Full throughput of 1 beat/cycle when out_ready is held high.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold stable.
- req_ready must not depend on out_valid/out_ready of the same cycle beyond can_accept. There is no path from req_ready back into req_valid.
- No combinational path from req_data* to out_data; the buffer is registered.
- A requester may deassert req_valid at any time without protocol violation. The lock persists until last or truncation.

Test Plan:
- Priority, single beats:
  - Stimulus: req_valid=4'b1110, all req_last=1, out_ready=1; data1=0x11111111, data2=0x22222222, data3=0x33333333.
  - Required: requester 1 served first, then 2, then 3, one per cycle.
  - Required: out_sel=0010, 0100, 1000 in turn, out_last=1 each time, req_ready one-hot each cycle.
- Burst lock:
  - Stimulus: requester 2 starts a 3-beat burst (last on beat 3). Requester 0 asserts valid after beat 1.
  - Required: beats 2 and 3 still come from requester 2 (out_sel=0100).
  - Required: requester 0 is served on the next cycle after beat 3.
- Truncation:
  - Stimulus: MAX_BURST=8, requester 3 streams with req_last held at 0.
  - Required: beat 8 has out_last=1, out_trunc=1; state returns to IDLE.
  - Required: re-arbitration then picks the lowest valid index.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with the buffer full.
  - Required: out_* stable and req_ready=0 throughout.
  - Stimulus: out_ready=1 together with pending req_valid.
  - Required: drain and refill in the same cycle; out_valid stays 1.
- Reset mid-burst:
  - Stimulus: assert reset during beat 2 of a requester-1 burst.
  - Required: next cycle out_valid=0, out_sel=0, req_ready=0 during reset.
  - Required: after reset deasserts, requester 0 is served first if it is valid.
- Idle:
  - Stimulus: req_valid=0.
  - Required: req_ready=0, out_valid drops after drain, out_sel=0.
